pipelined_ripple_adder: RTL and testbench

Parametrised, pipelined successor to the 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands as STAGES ripple slices, registering the carry between slices. A valid/ready handshake on both sides supports back-pressure. It is the datapath arithmetic unit for blocks that need wider operands than a single-cycle ripple chain can close timing on.

---
 rtl/rca_pkg.sv | 13 +
 rtl/rca_slice.sv | 29 ++
 rtl/pipelined_ripple_adder.sv | 150 +++++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder family.
package rca_pkg;

    // Encoding of the sub port.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Legal when STAGES is in 1..WIDTH and divides WIDTH exactly.
    function automatic bit params_legal(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple chain of full adders.
module rca_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [SLICE:0] carry;

    // Ripple the carry through one full adder per bit.
    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int unsigned i = 0; i < SLICE; i++) begin
            sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = carry[SLICE];
    assign cmsb_o = carry[SLICE-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract unit: STAGES ripple slices with registered carries,
// skewed operands, deskewed sums and a valid/ready handshake on both sides.
module pipelined_ripple_adder
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SLICE = WIDTH / STAGES;

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // Single advance enable: the whole pipeline moves or the whole pipeline holds.
    logic adv_en;
    assign adv_en   = !out_valid || out_ready;
    assign in_ready = adv_en;

    // Stage k owns operand bits [WIDTH-1:k*SLICE] still to be added and the
    // sum bits [k*SLICE+SLICE-1:0] completed once its slice has rippled.
    // Stages k>0 start with the boundary register fed by stage k-1.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned LO = k * SLICE;

        logic [WIDTH-1:LO]      op_a;
        logic [WIDTH-1:LO]      op_b;
        logic                   cy_in;
        logic                   vld;
        logic [LO+SLICE-1:0]    done;
        logic [SLICE-1:0]       sl_sum;
        logic                   sl_cout;
        logic                   sl_cmsb;

        if (k == 0) begin : g_in
            // Stage 0 forms the effective operands straight from the ports.
            always_comb begin
                op_a  = a;
                op_b  = (sub == OP_SUB) ? ~b : b;
                cy_in = (sub == OP_SUB) ? 1'b1 : cin;
                vld   = in_valid;
                done  = sl_sum;
            end
        end else begin : g_reg
            logic              v_q;
            logic              c_q;
            logic [WIDTH-1:LO] a_q;
            logic [WIDTH-1:LO] b_q;
            logic [LO-1:0]     s_q;

            // Boundary register: carry, valid, skewed operands, deskewed sums.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv_en) begin
                    v_q <= g_st[k-1].vld;
                    c_q <= g_st[k-1].sl_cout;
                    a_q <= g_st[k-1].op_a[WIDTH-1:LO];
                    b_q <= g_st[k-1].op_b[WIDTH-1:LO];
                    s_q <= g_st[k-1].done;
                end
            end

            // Present the registered state to this stage's slice.
            always_comb begin
                op_a  = a_q;
                op_b  = b_q;
                cy_in = c_q;
                vld   = v_q;
                done  = {sl_sum, s_q};
            end
        end

        rca_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a_i    (op_a[LO +: SLICE]),
            .b_i    (op_b[LO +: SLICE]),
            .cin_i  (cy_in),
            .sum_o  (sl_sum),
            .cout_o (sl_cout),
            .cmsb_o (sl_cmsb)
        );

        // Only the top slice's MSB carry feeds ovf.
        if (k != STAGES - 1) begin : g_sink
            logic cmsb_unused;
            assign cmsb_unused = sl_cmsb;
        end
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Output register next state: load from the last stage when advancing.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (adv_en) begin
            out_valid_d = g_st[STAGES-1].vld;
            sum_d       = g_st[STAGES-1].done;
            cout_d      = g_st[STAGES-1].sl_cout;
            ovf_d       = g_st[STAGES-1].sl_cmsb ^ g_st[STAGES-1].sl_cout;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder, plus a parameter sweep.
module tb_pipelined_ripple_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Sweep DUTs share operand and control drive.
    logic        sw_valid, sw_cin, sw_sub, sw_ready;
    logic [31:0] sw_a, sw_b;
    logic        r4, r16, r32, v4, v16, v32, c4, c16, c32, o4, o16, o32;
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [31:0] s32;

    pipelined_ripple_adder #(.WIDTH(4), .STAGES(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r4),
        .a(sw_a[3:0]), .b(sw_b[3:0]), .cin(sw_cin), .sub(sw_sub),
        .out_valid(v4), .out_ready(sw_ready), .sum(s4), .cout(c4), .ovf(o4)
    );
    pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r16),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub),
        .out_valid(v16), .out_ready(sw_ready), .sum(s16), .cout(c16), .ovf(o16)
    );
    pipelined_ripple_adder #(.WIDTH(32), .STAGES(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r32),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
        .out_valid(v32), .out_ready(sw_ready), .sum(s32), .cout(c32), .ovf(o32)
    );

    int checks, errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: returns {ovf, cout, sum[31:0]} for a w-bit unit.
    function automatic logic [33:0] ref_op(input int unsigned w, input logic [31:0] x,
                                           input logic [31:0] y, input logic ci, input logic s);
        logic [63:0] mask, m1, bb, full, low;
        logic        c_in, co, cm;
        mask = (64'd1 << w) - 64'd1;
        m1   = mask >> 1;
        bb   = (s ? ~{32'd0, y} : {32'd0, y}) & mask;
        c_in = s ? 1'b1 : ci;
        full = ({32'd0, x} & mask) + bb + {63'd0, c_in};
        low  = ({32'd0, x} & m1) + (bb & m1) + {63'd0, c_in};
        co   = full[w];
        cm   = low[w-1];
        return {cm ^ co, co, full[31:0] & mask[31:0]};
    endfunction

    // One isolated operation through the 8/2 unit: latency 2, then drain.
    task automatic run_single(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                              input logic tcin, input logic tsub,
                              input logic [7:0] es, input logic ec, input logic eo);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"},   sum, es);
        chk({tag, "_cout"},  cout, ec);
        chk({tag, "_ovf"},   ovf, eo);
        @(posedge clk); #1;
        chk({tag, "_drain"}, out_valid, 0);
    endtask

    // Back-pressure table with hand-computed results.
    logic [7:0] bp_a   [8] = '{8'h12, 8'hF0, 8'h40, 8'h10, 8'hAA, 8'h01, 8'h7F, 8'h90};
    logic [7:0] bp_b   [8] = '{8'h34, 8'h20, 8'h40, 8'h20, 8'h55, 8'h01, 8'h7F, 8'h70};
    logic       bp_cin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       bp_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] bp_es  [8] = '{8'h46, 8'h10, 8'h80, 8'hF0, 8'h00, 8'h00, 8'hFE, 8'h20};
    logic       bp_ec  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       bp_eo  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    int          idx, rd, cyc;
    logic        prev_stall, prev_c, prev_o;
    logic [7:0]  prev_sum;
    logic [33:0] e4, e16, e32;

    initial begin
        checks = 0; errors = 0;
        sw_valid = 1'b0; sw_cin = 1'b0; sw_sub = 1'b0; sw_ready = 1'b1; sw_a = '0; sw_b = '0;

        // Reset held two cycles with a valid operand offered.
        rst = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum",       sum, 0);
        chk("rst_cout",      cout, 0);
        chk("rst_ovf",       ovf, 0);
        chk("rst_in_ready",  in_ready, 1);
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_no_result", out_valid, 0);
        end

        // Directed single operations.
        run_single("add_0f_01",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        run_single("add_0f_cin", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        run_single("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_single("add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_single("sub_05_07",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_single("sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_single("sub_00_00",  8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        run_single("add_80_80",  8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Back-pressure: out_ready toggles 1,0,1,0...
        idx = 0; rd = 0; cyc = 0; prev_stall = 1'b0;
        prev_sum = '0; prev_c = 1'b0; prev_o = 1'b0;
        while (rd < 8 && cyc < 64) begin
            out_ready = (cyc % 2 == 0);
            if (idx < 8) begin
                in_valid = 1'b1; a = bp_a[idx]; b = bp_b[idx]; cin = bp_cin[idx]; sub = bp_sub[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_sum",   sum, prev_sum);
                chk("bp_hold_cout",  cout, prev_c);
                chk("bp_hold_ovf",   ovf, prev_o);
            end
            if (out_valid && !out_ready) chk("bp_stall_in_ready", in_ready, 0);
            if (out_valid) begin
                chk("bp_sum",  sum, bp_es[rd]);
                chk("bp_cout", cout, bp_ec[rd]);
                chk("bp_ovf",  ovf, bp_eo[rd]);
                if (out_ready) rd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sum = sum; prev_c = cout; prev_o = ovf;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_results_count", rd, 8);
        chk("bp_issued_count",  idx, 8);

        // Full throughput: one result per cycle with out_ready held high.
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; a = bp_a[c]; b = bp_b[c]; cin = bp_cin[c]; sub = bp_sub[c];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (c >= 1) begin
                chk("tp_valid", out_valid, 1);
                chk("tp_sum",   sum, bp_es[c-1]);
                chk("tp_cout",  cout, bp_ec[c-1]);
            end
        end
        @(posedge clk); #1;
        chk("tp_drain", out_valid, 0);

        // Reset with two operations in flight.
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 8'h03; b = 8'h04;
        @(posedge clk); #1;
        chk("mr_x_valid", out_valid, 1);
        chk("mr_x_sum",   sum, 8'h03);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mr_flush_valid", out_valid, 0);
        chk("mr_flush_sum",   sum, 0);
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("mr_no_stale", out_valid, 0);
        end
        run_single("mr_after", 8'h21, 8'h03, 1'b0, 1'b0, 8'h24, 1'b0, 1'b0);

        // Parameter sweep: (4,1), (16,4), (32,8), checked at each latency.
        for (int n = 0; n < 12; n++) begin
            if (n == 0) begin
                sw_a = 32'hFFFF_FFFF; sw_b = 32'h0000_0001; sw_cin = 1'b0; sw_sub = 1'b0;
            end else if (n == 1) begin
                sw_a = 32'h8000_8008; sw_b = 32'h0000_0001; sw_cin = 1'b0; sw_sub = 1'b1;
            end else begin
                sw_a = $urandom; sw_b = $urandom;
                sw_cin = 1'($urandom_range(1)); sw_sub = 1'($urandom_range(1));
            end
            e4  = ref_op(4,  sw_a, sw_b, sw_cin, sw_sub);
            e16 = ref_op(16, sw_a, sw_b, sw_cin, sw_sub);
            e32 = ref_op(32, sw_a, sw_b, sw_cin, sw_sub);
            sw_valid = 1'b1;
            #1;
            chk("sw_in_ready", {r4, r16, r32}, 3'b111);
            for (int e = 1; e <= 8; e++) begin
                @(posedge clk); #1;
                sw_valid = 1'b0;
                chk("sw4_valid",  v4,  (e == 1));
                chk("sw16_valid", v16, (e == 4));
                chk("sw32_valid", v32, (e == 8));
                if (e == 1) chk("sw4_result",  {o4, c4, s4},    {e4[33:32], e4[3:0]});
                if (e == 4) chk("sw16_result", {o16, c16, s16}, {e16[33:32], e16[15:0]});
                if (e == 8) chk("sw32_result", {o32, c32, s32}, e32);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
